// File: rtl/uart_tx.sv
// uart_tx: 8N1 UART transmitter with valid/ready byte input and burst busy tracking.
// Define UART_TX_PARITY_EN to insert an even-parity bit between the data and stop bits.
`timescale 1ns/1ps
module uart_tx #(
  parameter     IS_SIM           = "TRUE",
  parameter     BAUD_RATE        = "115200",
  parameter int UART_DATA_WID    = 8,
  parameter int UART_TX_DATA_NUM = 82
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [UART_DATA_WID-1:0] iv_tx_data,
  input  logic                     i_tx_data_vld,
  output logic                     o_tx_ready,
  output logic                     o_tx,
  output logic                     o_tx_done,
  output logic                     o_tx_busy
);

  localparam int BAUD_RATE_CNT_NUM = (IS_SIM == "TRUE") ? 10 :
                                     ((BAUD_RATE == "115200") ? 868 : 10416);
`ifdef UART_TX_PARITY_EN
  localparam int BIT_CNT_NUM = UART_DATA_WID + 3;
`else
  localparam int BIT_CNT_NUM = UART_DATA_WID + 2;
`endif
  localparam int BAUD_W = $clog2(BAUD_RATE_CNT_NUM);
  localparam int BIT_W  = $clog2(BIT_CNT_NUM);
  localparam int BYTE_W = (UART_TX_DATA_NUM > 1) ? $clog2(UART_TX_DATA_NUM) : 1;

  localparam logic [BAUD_W-1:0] BAUD_LAST     = BAUD_W'(BAUD_RATE_CNT_NUM - 1);
  localparam logic [BIT_W-1:0]  DATA_LAST_BIT = BIT_W'(UART_DATA_WID);
  localparam logic [BYTE_W-1:0] BYTE_LAST     = BYTE_W'(UART_TX_DATA_NUM - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_TX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  state_t                   state_reg, state_next;
  logic [BAUD_W-1:0]        baud_cnt_reg, baud_cnt_next;
  logic [BIT_W-1:0]         bit_cnt_reg, bit_cnt_next;
  logic [BYTE_W-1:0]        byte_cnt_reg;
  logic [UART_DATA_WID-1:0] shift_reg, shift_next;
  logic                     tx_reg, tx_next;
  logic                     busy_reg;
  logic                     baud_tc;
  logic                     tx_accept;
  logic                     tx_done;
`ifdef UART_TX_PARITY_EN
  logic                     parity_reg;
`endif

  assign baud_tc = (baud_cnt_reg == BAUD_LAST);

  // bit_cnt indexes the frame slot: 0 = start, 1..UART_DATA_WID = data, then parity/stop
  always_comb begin
    state_next    = state_reg;
    baud_cnt_next = '0;
    bit_cnt_next  = bit_cnt_reg;
    shift_next    = shift_reg;
    tx_next       = 1'b1;
    tx_accept     = 1'b0;
    tx_done       = 1'b0;
    if (state_reg != IDLE) begin
      baud_cnt_next = baud_tc ? '0 : baud_cnt_reg + BAUD_W'(1);
      if (baud_tc) bit_cnt_next = bit_cnt_reg + BIT_W'(1);
    end
    case (state_reg)
      IDLE: begin
        if (i_tx_data_vld) begin
          tx_accept  = 1'b1;
          state_next = START;
          shift_next = iv_tx_data;
        end
      end
      START: if (baud_tc) state_next = DATA;
      DATA: begin
        if (baud_tc) begin
          shift_next = shift_reg >> 1;
`ifdef UART_TX_PARITY_EN
          if (bit_cnt_reg == DATA_LAST_BIT) state_next = PARITY;
`else
          if (bit_cnt_reg == DATA_LAST_BIT) state_next = STOP;
`endif
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: if (baud_tc) state_next = STOP;
`endif
      STOP: begin
        if (baud_tc) begin
          state_next   = IDLE;
          bit_cnt_next = '0;
          tx_done      = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
    // Line level follows the next state so o_tx can come straight from a flop
    case (state_next)
      START:   tx_next = 1'b0;
      DATA:    tx_next = shift_next[0];
`ifdef UART_TX_PARITY_EN
      PARITY:  tx_next = parity_reg;
`endif
      default: tx_next = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg    <= IDLE;
      baud_cnt_reg <= '0;
      bit_cnt_reg  <= '0;
      byte_cnt_reg <= '0;
      shift_reg    <= '0;
      tx_reg       <= 1'b1;
      busy_reg     <= 1'b0;
    end else begin
      state_reg    <= state_next;
      baud_cnt_reg <= baud_cnt_next;
      bit_cnt_reg  <= bit_cnt_next;
      shift_reg    <= shift_next;
      tx_reg       <= tx_next;
      if (tx_done)
        byte_cnt_reg <= (byte_cnt_reg == BYTE_LAST) ? '0 : byte_cnt_reg + BYTE_W'(1);
      // Burst end takes priority over a burst start
      if (tx_done && (byte_cnt_reg == BYTE_LAST))
        busy_reg <= 1'b0;
      else if (tx_accept && (byte_cnt_reg == '0))
        busy_reg <= 1'b1;
    end
  end

`ifdef UART_TX_PARITY_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      parity_reg <= 1'b0;
    else if (tx_accept)
      parity_reg <= ^iv_tx_data;
  end
`endif

  assign o_tx       = tx_reg;
  assign o_tx_ready = (state_reg == IDLE);
  assign o_tx_done  = tx_done;
  assign o_tx_busy  = busy_reg;

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: directed bench for uart_tx with an accept-time scoreboard and a serial receiver model.
// Build with UART_TX_PARITY_EN defined to exercise the parity frame as well.
`timescale 1ns/1ps
module tb_uart_tx;
  localparam int BAUD = 10;
`ifdef UART_TX_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif
  localparam int LAST = FRAME_BITS * BAUD - 1;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] iv_tx_data = 8'h00;
  logic       i_tx_data_vld = 1'b0;
  logic       o_tx_ready, o_tx, o_tx_done, o_tx_busy;

  int         vectors = 0;
  int         miscompares = 0;
  int         cyc = 0;
  logic [7:0] sb[$];
  int         acc_cyc[$];

  uart_tx #(
    .IS_SIM("TRUE"),
    .BAUD_RATE("115200"),
    .UART_DATA_WID(8),
    .UART_TX_DATA_NUM(3)
  ) dut (
    .clk(clk),
    .rst(rst),
    .iv_tx_data(iv_tx_data),
    .i_tx_data_vld(i_tx_data_vld),
    .o_tx_ready(o_tx_ready),
    .o_tx(o_tx),
    .o_tx_done(o_tx_done),
    .o_tx_busy(o_tx_busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard push at the handshake edge
  always @(posedge clk) begin
    if (rst && i_tx_data_vld && o_tx_ready) begin
      sb.push_back(iv_tx_data);
      acc_cyc.push_back(cyc);
    end
  end

  // Receiver model: samples each bit at its centre
  bit         mon_active = 1'b0;
  int         mon_cnt = 0;
  int         mon_k;
  logic [7:0] mon_byte = 8'h00;
  logic [7:0] mon_exp;
  always @(negedge clk) begin
    if (!rst) begin
      mon_active = 1'b0;
    end else if (!mon_active) begin
      if (o_tx === 1'b0) begin
        mon_active = 1'b1;
        mon_cnt    = 0;
      end
    end else begin
      mon_cnt++;
      if (mon_cnt % BAUD == BAUD / 2) begin
        mon_k = mon_cnt / BAUD;
        if (mon_k == 0) check("rx_start", o_tx, 0);
        else if (mon_k <= 8) mon_byte[mon_k-1] = o_tx;
`ifdef UART_TX_PARITY_EN
        else if (mon_k == 9) check("rx_parity", o_tx, ^mon_byte);
`endif
        else begin
          check("rx_stop", o_tx, 1);
          check("rx_sb_nonempty", sb.size() != 0, 1);
          if (sb.size() != 0) begin
            mon_exp = sb.pop_front();
            check("rx_byte", mon_byte, mon_exp);
            $display("rx frame: got 0x%02h expected 0x%02h", mon_byte, mon_exp);
          end
          mon_active = 1'b0;
        end
      end
    end
  end

  task automatic send(input logic [7:0] d, input bit hold);
    int n = 0;
    iv_tx_data    = d;
    i_tx_data_vld = 1'b1;
    while (o_tx_ready !== 1'b1 && n < 2000) begin
      @(posedge clk); #1;
      n++;
    end
    check("send_ready_wait", n < 2000, 1);
    @(posedge clk); #1;
    if (!hold) i_tx_data_vld = 1'b0;
  endtask

  task automatic wait_done(input string tag, output int idx);
    idx = 0;
    forever begin
      @(negedge clk);
      if (o_tx_done === 1'b1 || idx >= 2000) break;
      idx++;
    end
    check(tag, idx, LAST);
  endtask

  int         n, errs, done_errs, exp_bit;
  logic [7:0] d55 = 8'h55;

  initial begin
    // Reset state
    repeat (5) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    check("rst_tx", o_tx, 1);
    check("rst_ready", o_tx_ready, 1);
    check("rst_busy", o_tx_busy, 0);
    check("rst_done", o_tx_done, 0);

    // Single byte with exact bit timing
    send(d55, 1'b0);
    check("busy_first_accept", o_tx_busy, 1);
    check("ready_drop", o_tx_ready, 0);
    done_errs = 0;
    for (int b = 0; b < FRAME_BITS; b++) begin
      if (b == 0) exp_bit = 0;
      else if (b <= 8) exp_bit = int'(d55[b-1]);
      else if (b == FRAME_BITS - 1) exp_bit = 1;
      else exp_bit = int'(^d55);
      errs = 0;
      for (int j = 0; j < BAUD; j++) begin
        @(negedge clk);
        if (o_tx !== exp_bit[0]) errs++;
        if (o_tx_done !== ((b * BAUD + j) == LAST)) done_errs++;
      end
      check($sformatf("bit%0d_level", b), errs, 0);
    end
    check("done_position", done_errs, 0);
    @(negedge clk);
    check("ready_after_done", o_tx_ready, 1);
    check("done_single_pulse", o_tx_done, 0);

    // Back-to-back with held valid; input changes while busy must not leak
    send(8'hA3, 1'b1);
    iv_tx_data = 8'hEE;
    repeat (40) @(negedge clk);
    send(8'h0F, 1'b0);
    check("b2b_spacing", acc_cyc[acc_cyc.size()-1] - acc_cyc[acc_cyc.size()-2], LAST + 2);
    check("busy_mid_burst", o_tx_busy, 1);
    wait_done("burst_done_pos", n);
    check("busy_at_last_done", o_tx_busy, 1);
    @(negedge clk);
    check("busy_cleared", o_tx_busy, 0);

    // New burst after the byte counter wrapped
    send(8'h3C, 1'b0);
    check("busy_rearm", o_tx_busy, 1);
    wait_done("fourth_done_pos", n);
    @(negedge clk);

    // Asynchronous reset in data bit 4
    send(8'hFF, 1'b0);
    repeat (55) @(negedge clk);
    check("pre_rst_ready", o_tx_ready, 0);
    #2 rst = 1'b0;
    #1;
    check("async_rst_tx", o_tx, 1);
    check("async_rst_ready", o_tx_ready, 1);
    check("async_rst_busy", o_tx_busy, 0);
    errs = 0;
    repeat (3) begin
      @(negedge clk);
      if (o_tx !== 1'b1 || o_tx_done !== 1'b0) errs++;
    end
    check("rst_hold_quiet", errs, 0);
    sb.delete();
    @(posedge clk); #1 rst = 1'b1;
    send(8'h81, 1'b0);
    check("post_rst_busy", o_tx_busy, 1);
    wait_done("post_rst_done_pos", n);
    @(negedge clk);

`ifdef UART_TX_PARITY_EN
    send(8'h07, 1'b0);
    errs = 0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (i == 95) check("parity_bit", o_tx, 1);
      if (o_tx_done === 1'b1) begin
        check("parity_frame_len", i + 1, 110);
        break;
      end
      if (i == 1999) check("parity_done_seen", 0, 1);
    end
    @(negedge clk);
`endif

    repeat (5) @(negedge clk);
    check("sb_drained", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
- Serial UART transmitter for the host link, 8N1 framing: start bit 0, then data LSB first, then stop bit 1.
- Takes bytes from the packet-return logic (nonce/result reporter) over a valid/ready handshake and serialises them on the TX pin.
- Counts bytes in a fixed-length burst and holds a busy flag from the first byte of a burst until the last byte has been sent.
- Baud timing is derived from the 100 MHz system clock.

Parameters:
- IS_SIM, "TRUE": "TRUE" forces BAUD_RATE_CNT_NUM = 10 for simulation; "FALSE" selects the real baud count.
- BAUD_RATE, "115200": "115200" gives BAUD_RATE_CNT_NUM = 868; "9600" or any other value gives 10416.
- UART_DATA_WID, 8: data bits per frame.
- UART_TX_DATA_NUM, 82: bytes per burst; sets the byte-counter wrap and the busy span.

Ports:
- clk  in  1  system clock, 100 MHz.
- rst  in  1  asynchronous, active-low reset.
- iv_tx_data  in  UART_DATA_WID  byte to send; sampled on accept.
- i_tx_data_vld  in  1  iv_tx_data is valid.
- o_tx_ready  out  1  transmitter can accept a byte.
- o_tx  out  1  serial TX line, idle high.
- o_tx_done  out  1  one-cycle pulse on the last cycle of each stop bit.
- o_tx_busy  out  1  burst in progress.

Behaviour:
- Reset (rst=0, asynchronous):
  - Outputs: o_tx=1, o_tx_ready=1, o_tx_done=0, o_tx_busy=0.
  - Internals: state=IDLE; baud, bit and byte counters=0; shift register=0.
  - Reset in mid-frame aborts the frame immediately; the line returns high with no glitch low.
- Localparams:
  - BIT_CNT_NUM = UART_DATA_WID + 2 (+1 with parity).
  - Counter widths use ceil(log2(N)).
- Accept: a byte is accepted when i_tx_data_vld && o_tx_ready.
  - iv_tx_data is latched into the shift register.
  - o_tx_ready is deasserted the next cycle.
  - i_tx_data_vld while o_tx_ready=0 is ignored; the source must hold the byte until accepted.
- FSM states: IDLE -> START -> DATA -> STOP -> IDLE.
  - IDLE: o_tx=1, o_tx_ready=1. On accept, go to START.
  - START: o_tx=0 for BAUD_RATE_CNT_NUM cycles.
  - DATA: o_tx = shift[0]. Shift right at each baud terminal count. After UART_DATA_WID bits, go to STOP.
  - STOP: o_tx=1 for BAUD_RATE_CNT_NUM cycles. On its last cycle, o_tx_done=1 and the next state is IDLE.
- Baud counter:
  - Runs 0..BAUD_RATE_CNT_NUM-1 while not IDLE; wraps to 0 at terminal count.
  - Held at 0 in IDLE.
- o_tx is registered and glitch-free.
  - Start bit begins the cycle after accept.
  - Every bit lasts exactly BAUD_RATE_CNT_NUM cycles.
- Back-to-back bytes:
  - o_tx_ready rises the cycle after o_tx_done.
  - Minimum accept-to-accept spacing is BIT_CNT_NUM*BAUD_RATE_CNT_NUM + 1 cycles.
- Byte counter:
  - Increments on each o_tx_done.
  - At UART_TX_DATA_NUM-1 plus o_tx_done it wraps to 0.
- o_tx_busy:
  - Set on the accept cycle when the byte counter is 0.
  - Cleared on the o_tx_done that wraps the byte counter.
  - If an accept and the clearing done could coincide, clear wins; in practice they cannot coincide, because ready is low during done.
- Bits are sent LSB first. There is no output FIFO; the block buffers exactly one byte.

Optional Feature:
- Macro: UART_TX_PARITY_EN.
- Defined:
  - A PARITY state is inserted between DATA and STOP.
  - PARITY drives the even-parity bit (XOR of the data bits) for one bit time.
  - BIT_CNT_NUM becomes UART_DATA_WID + 3, and the frame is 11 bit-times at default width.
- Undefined:
  - No parity state; 8N1 framing as above.
  - No parity logic is synthesised.

Test Plan:
- Reset state: IS_SIM="TRUE", hold rst=0 for 5 cycles, then release -> o_tx=1, o_tx_ready=1, o_tx_busy=0, o_tx_done=0.
- Single byte: send 0x55 -> o_tx is 0 then 1,0,1,0,1,0,1,0 then 1, each level exactly 10 cycles.
  - The start bit begins 1 cycle after accept.
  - o_tx_done pulses once, 100 cycles after the start-bit edge begins.
  - o_tx_ready returns 1 cycle later.
- Handshake and back-to-back: hold vld with 0xA3 then 0x0F continuously.
  - Second accept occurs exactly 101 cycles after the first.
  - iv_tx_data changes while ready=0 do not corrupt the frame in flight.
  - A receiver model decodes 0xA3, 0x0F.
- Burst and busy: UART_TX_DATA_NUM=3, send 3 bytes.
  - o_tx_busy rises on the first accept and falls on the third o_tx_done.
  - The byte counter wraps to 0.
  - A fourth byte sets busy again.
- Reset mid-frame: assert rst during data bit 4 of 0xFF.
  - o_tx=1 asynchronously, with no done pulse.
  - After release, the next byte 0x81 is sent with correct framing.
- Parity (UART_TX_PARITY_EN defined): send 0x07 -> parity bit 1, frame of 110 cycles, o_tx_done at the end of the stop bit.
